// File: rtl/pipe_reg_if.sv
// rtl/pipe_reg_if.sv - handshake bundle between pipe_reg and its neighbours
//
// Purpose: groups the upstream and downstream valid/ready/data signals of
// pipe_reg into one interface.
// Signals:
//   pipe_reg_valid_in   upstream presents data
//   pipe_reg_data_in    upstream data (DATA_WIDTH bits)
//   pipe_reg_ready_out  block can accept upstream data this cycle
//   pipe_reg_valid_out  block presents data downstream
//   pipe_reg_data_out   downstream data (DATA_WIDTH bits)
//   pipe_reg_ready_in   downstream accepts data this cycle
//   pipe_reg_count_out  number of held entries (0, 1 or 2)
// Modports:
//   slave   the pipe_reg side
//   master  the environment side (drives the *_in signals)
interface pipe_reg_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  pipe_reg_valid_in;
  logic [DATA_WIDTH-1:0] pipe_reg_data_in;
  logic                  pipe_reg_ready_out;
  logic                  pipe_reg_valid_out;
  logic [DATA_WIDTH-1:0] pipe_reg_data_out;
  logic                  pipe_reg_ready_in;
  logic [1:0]            pipe_reg_count_out;

  modport slave (
    input  pipe_reg_valid_in,
    input  pipe_reg_data_in,
    output pipe_reg_ready_out,
    output pipe_reg_valid_out,
    output pipe_reg_data_out,
    input  pipe_reg_ready_in,
    output pipe_reg_count_out
  );

  modport master (
    output pipe_reg_valid_in,
    output pipe_reg_data_in,
    input  pipe_reg_ready_out,
    input  pipe_reg_valid_out,
    input  pipe_reg_data_out,
    output pipe_reg_ready_in,
    input  pipe_reg_count_out
  );
endinterface

// File: rtl/pipe_reg.sv
// rtl/pipe_reg.sv - two-entry skid buffer pipeline register
//
// Purpose: registers a valid/ready stream with one cycle of latency and full
// throughput. A main register drives the output; a skid register catches the
// one word that arrives while the downstream stalls, so ready_out depends only
// on registered state.
// Ports:
//   pipe_reg_clock_in   clock, all state updates on the rising edge
//   pipe_reg_reset_in   synchronous active-high reset
//   pipe_reg_flush_in   synchronous discard of all held entries
//   pipe_reg_bus        pipe_reg_if.slave handshake bundle (see pipe_reg_if)
module pipe_reg #(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic      pipe_reg_clock_in,
  input  logic      pipe_reg_reset_in,
  input  logic      pipe_reg_flush_in,
  pipe_reg_if.slave pipe_reg_bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [DATA_WIDTH-1:0] main_q;
  logic [DATA_WIDTH-1:0] main_d;
  logic [DATA_WIDTH-1:0] skid_q;
  logic [DATA_WIDTH-1:0] skid_d;

  logic ready_int;
  logic valid_int;
  logic push;
  logic pop;

  // Handshake qualifiers come from state only; reset masking is applied to
  // the visible outputs further down, and reset wins in the register anyway.
  assign ready_int = (state_q != ST_TWO);
  assign valid_int = (state_q == ST_ONE) || (state_q == ST_TWO);
  assign push      = pipe_reg_bus.pipe_reg_valid_in && ready_int;
  assign pop       = valid_int && pipe_reg_bus.pipe_reg_ready_in;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (pipe_reg_flush_in) begin
      state_d = ST_EMPTY;
      main_d  = RESET_VALUE;
      skid_d  = RESET_VALUE;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d = ST_ONE;
            main_d  = pipe_reg_bus.pipe_reg_data_in;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            main_d = pipe_reg_bus.pipe_reg_data_in;
          end else if (push) begin
            // Downstream stalled: park the new word, keep main stable.
            state_d = ST_TWO;
            skid_d  = pipe_reg_bus.pipe_reg_data_in;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          // Unencoded state value: drop back to a known empty buffer.
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge pipe_reg_clock_in) begin
    if (pipe_reg_reset_in) begin
      state_q <= ST_EMPTY;
      main_q  <= RESET_VALUE;
      skid_q  <= RESET_VALUE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Handshake outputs are held low for as long as reset is asserted so that
  // neither neighbour sees a transfer that the register is about to discard.
  assign pipe_reg_bus.pipe_reg_ready_out = ready_int && !pipe_reg_reset_in;
  assign pipe_reg_bus.pipe_reg_valid_out = valid_int && !pipe_reg_reset_in;
  assign pipe_reg_bus.pipe_reg_data_out  = main_q;

  always_comb begin
    pipe_reg_bus.pipe_reg_count_out = 2'd0;
    case (state_q)
      ST_ONE:  pipe_reg_bus.pipe_reg_count_out = 2'd1;
      ST_TWO:  pipe_reg_bus.pipe_reg_count_out = 2'd2;
      default: pipe_reg_bus.pipe_reg_count_out = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_pipe_reg.sv
// tb/tb_pipe_reg.sv - self-checking directed and random bench for pipe_reg
module tb_pipe_reg;

  localparam int DW = 32;

  logic clk;
  logic rst;
  logic flush;
  int   total;
  int   bad;

  pipe_reg_if #(.DATA_WIDTH(DW)) bus ();

  pipe_reg #(
    .DATA_WIDTH (DW),
    .RESET_VALUE(32'h0)
  ) dut (
    .pipe_reg_clock_in(clk),
    .pipe_reg_reset_in(rst),
    .pipe_reg_flush_in(flush),
    .pipe_reg_bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then read 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_two(input logic [DW-1:0] a, input logic [DW-1:0] b);
    bus.pipe_reg_ready_in = 1'b0;
    bus.pipe_reg_valid_in = 1'b1;
    bus.pipe_reg_data_in  = a;
    step();
    bus.pipe_reg_data_in  = b;
    step();
    bus.pipe_reg_valid_in = 1'b0;
    chk("fill_count", 64'(bus.pipe_reg_count_out), 64'd2);
  endtask

  task automatic chk_post_reset(input string tag);
    chk({tag, "_data"},  64'(bus.pipe_reg_data_out),  64'h0);
    chk({tag, "_count"}, 64'(bus.pipe_reg_count_out), 64'd0);
    chk({tag, "_valid"}, 64'(bus.pipe_reg_valid_out), 64'd0);
    chk({tag, "_ready"}, 64'(bus.pipe_reg_ready_out), 64'd1);
  endtask

  logic [DW-1:0] q[$];
  logic [DW-1:0] held;
  logic          stalled;
  logic          exp_ready;
  logic          do_push;
  logic          do_pop;

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    flush = 1'b0;
    bus.pipe_reg_valid_in = 1'b0;
    bus.pipe_reg_data_in  = '0;
    bus.pipe_reg_ready_in = 1'b0;
    #1;
    chk("rst_hold_ready", 64'(bus.pipe_reg_ready_out), 64'd0);
    chk("rst_hold_valid", 64'(bus.pipe_reg_valid_out), 64'd0);
    step();
    step();
    rst = 1'b0;
    #1;
    chk_post_reset("post_reset");

    // Single push straight after reset release, downstream stalled.
    bus.pipe_reg_valid_in = 1'b1;
    bus.pipe_reg_data_in  = 32'hDEADBEEF;
    step();
    bus.pipe_reg_valid_in = 1'b0;
    chk("single_valid", 64'(bus.pipe_reg_valid_out), 64'd1);
    chk("single_data",  64'(bus.pipe_reg_data_out),  64'hDEADBEEF);
    chk("single_count", 64'(bus.pipe_reg_count_out), 64'd1);
    chk("single_ready", 64'(bus.pipe_reg_ready_out), 64'd1);
    bus.pipe_reg_ready_in = 1'b1;
    step();
    chk("single_drain_count", 64'(bus.pipe_reg_count_out), 64'd0);

    // Skid fill, stall, then drain.
    push_two(32'h11, 32'h22);
    chk("skid_ready", 64'(bus.pipe_reg_ready_out), 64'd0);
    chk("skid_data",  64'(bus.pipe_reg_data_out),  64'h11);
    step();
    chk("skid_stall_data", 64'(bus.pipe_reg_data_out), 64'h11);
    bus.pipe_reg_ready_in = 1'b1;
    #1;
    chk("drain0_data", 64'(bus.pipe_reg_data_out), 64'h11);
    step();
    chk("drain1_data",  64'(bus.pipe_reg_data_out),  64'h22);
    chk("drain1_valid", 64'(bus.pipe_reg_valid_out), 64'd1);
    step();
    chk("drain_empty_valid", 64'(bus.pipe_reg_valid_out), 64'd0);

    // Streaming at full rate.
    for (int i = 1; i <= 8; i++) begin
      bus.pipe_reg_valid_in = 1'b1;
      bus.pipe_reg_data_in  = 32'(i);
      step();
      chk($sformatf("stream%0d_data", i), 64'(bus.pipe_reg_data_out), 64'(i));
      chk($sformatf("stream%0d_valid", i), 64'(bus.pipe_reg_valid_out), 64'd1);
      chk($sformatf("stream%0d_count", i), 64'(bus.pipe_reg_count_out), 64'd1);
      chk($sformatf("stream%0d_ready", i), 64'(bus.pipe_reg_ready_out), 64'd1);
    end
    bus.pipe_reg_valid_in = 1'b0;
    step();
    chk("stream_end_valid", 64'(bus.pipe_reg_valid_out), 64'd0);

    // Flush while full, with a concurrent push and pop attempt.
    push_two(32'hA1, 32'hA2);
    flush = 1'b1;
    bus.pipe_reg_valid_in = 1'b1;
    bus.pipe_reg_data_in  = 32'hBB;
    bus.pipe_reg_ready_in = 1'b1;
    step();
    flush = 1'b0;
    bus.pipe_reg_valid_in = 1'b0;
    chk("flush_count", 64'(bus.pipe_reg_count_out), 64'd0);
    chk("flush_valid", 64'(bus.pipe_reg_valid_out), 64'd0);
    chk("flush_data",  64'(bus.pipe_reg_data_out),  64'h0);
    step();
    chk("flush_after_valid", 64'(bus.pipe_reg_valid_out), 64'd0);

    // Reset mid-operation with flush, push and pop all asserted.
    push_two(32'hC1, 32'hC2);
    rst   = 1'b1;
    flush = 1'b1;
    bus.pipe_reg_valid_in = 1'b1;
    bus.pipe_reg_data_in  = 32'hCC;
    bus.pipe_reg_ready_in = 1'b1;
    #1;
    chk("midrst_ready0", 64'(bus.pipe_reg_ready_out), 64'd0);
    chk("midrst_valid0", 64'(bus.pipe_reg_valid_out), 64'd0);
    step();
    chk("midrst_ready1", 64'(bus.pipe_reg_ready_out), 64'd0);
    chk("midrst_valid1", 64'(bus.pipe_reg_valid_out), 64'd0);
    rst   = 1'b0;
    flush = 1'b0;
    bus.pipe_reg_valid_in = 1'b0;
    bus.pipe_reg_ready_in = 1'b0;
    #1;
    chk_post_reset("midrst_release");

    // Random traffic against a queue model.
    q.delete();
    stalled = 1'b0;
    held    = '0;
    for (int n = 0; n < 10000; n++) begin
      bus.pipe_reg_valid_in = 1'($urandom_range(0, 1));
      bus.pipe_reg_ready_in = 1'($urandom_range(0, 3) != 0);
      bus.pipe_reg_data_in  = $urandom;
      #1;
      exp_ready = (q.size() < 2);
      chk("rnd_ready", 64'(bus.pipe_reg_ready_out), 64'(exp_ready));
      chk("rnd_count", 64'(bus.pipe_reg_count_out), 64'(q.size()));
      chk("rnd_valid", 64'(bus.pipe_reg_valid_out), 64'(q.size() != 0));
      if (stalled)
        chk("rnd_stable", 64'(bus.pipe_reg_data_out), 64'(held));
      do_push = bus.pipe_reg_valid_in && exp_ready;
      do_pop  = (q.size() != 0) && bus.pipe_reg_ready_in;
      if (do_pop)
        chk("rnd_order", 64'(bus.pipe_reg_data_out), 64'(q[0]));
      stalled = (q.size() != 0) && !bus.pipe_reg_ready_in;
      held    = (q.size() != 0) ? q[0] : '0;
      if (do_pop)
        void'(q.pop_front());
      if (do_push)
        q.push_back(bus.pipe_reg_data_in);
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
